// File: rtl/xdma_pkg.sv
// Shared XDMA definitions: MMIO window layout, from-remote message structs and
// the receive-path state/response encodings.
package xdma_pkg;

  localparam int unsigned AddrWidth    = 48;
  localparam int unsigned AxiDataWidth = 512;
  localparam int unsigned DmaIdWidth   = 8;
  localparam int unsigned NumWindows   = 4;

  localparam logic [AddrWidth-1:0] ClusterAddressSpace = 48'h0000_0010_0000;
  localparam logic [AddrWidth-1:0] MMIOSize            = 48'h0000_0000_1000;
  localparam int unsigned          MMIOSizeShift       = 12;

  // Windows are stacked downward from the top of the cluster space.
  localparam logic [AddrWidth-1:0] MMIOFinishOffset = ClusterAddressSpace - 1 * MMIOSize;
  localparam logic [AddrWidth-1:0] MMIOGrantOffset  = ClusterAddressSpace - 2 * MMIOSize;
  localparam logic [AddrWidth-1:0] MMIOCfgOffset    = ClusterAddressSpace - 3 * MMIOSize;
  localparam logic [AddrWidth-1:0] MMIODataOffset   = ClusterAddressSpace - 4 * MMIOSize;
  localparam logic [AddrWidth-1:0] MMIOWindowSpan   = ClusterAddressSpace - MMIODataOffset;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    IdxFinish = 2'd0,
    IdxGrant  = 2'd1,
    IdxCfg    = 2'd2,
    IdxData   = 2'd3
  } xdma_from_remote_idx_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StResp  = 2'd2
  } xdma_rx_state_e;

  typedef struct packed {
    logic [DmaIdWidth-1:0] dma_id;
    logic [AddrWidth-1:0]  from;
  } xdma_from_remote_grant_t;

  typedef struct packed {
    logic [DmaIdWidth-1:0] dma_id;
    logic [AddrWidth-1:0]  from;
  } xdma_from_remote_finish_t;

  localparam int unsigned CfgReservedWidth = AxiDataWidth - 2 * 8 - 2 * AddrWidth - 32;

  typedef struct packed {
    logic [DmaIdWidth-1:0]       dma_id;
    logic [7:0]                  dma_type;
    logic [AddrWidth-1:0]        reader_addr;
    logic [AddrWidth-1:0]        writer_addr;
    logic [31:0]                 len;
    logic [CfgReservedWidth-1:0] reserved;
  } xdma_inter_cluster_cfg_t;

endpackage

// File: rtl/xdma_mmio_window_decode.sv
// Maps an absolute address onto one of the four XDMA MMIO windows at the top
// of the cluster address space; anything else is reported as a miss.
module xdma_mmio_window_decode
  import xdma_pkg::*;
(
  input  logic [AddrWidth-1:0] addr,
  input  logic [AddrWidth-1:0] base,
  output xdma_from_remote_idx_e idx,
  output logic                 miss
);

  logic [AddrWidth-1:0] offset;
  logic [AddrWidth-1:0] from_top;

  // Distance below the top of the cluster space selects the window; an address
  // below base wraps to a huge offset and therefore misses as well.
  always_comb begin
    offset   = addr - base;
    from_top = ClusterAddressSpace - AddrWidth'(1) - offset;
    miss     = !((offset < ClusterAddressSpace) && (from_top < MMIOWindowSpan));
    idx      = xdma_from_remote_idx_e'(from_top[MMIOSizeShift +: 2]);
  end

endmodule

// File: rtl/xdma_from_remote_demux.sv
// Receive-side demux of the XDMA inter-cluster link: classifies remote write
// bursts by MMIO window and forwards them as grant/finish/cfg/data streams.
module xdma_from_remote_demux
  import xdma_pkg::*;
#(
  parameter int unsigned AddrWidth = xdma_pkg::AddrWidth,
  parameter int unsigned DataWidth = xdma_pkg::AxiDataWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [AddrWidth-1:0]     cluster_base_addr_i,
  input  logic                     aw_valid_i,
  output logic                     aw_ready_o,
  input  logic [AddrWidth-1:0]     aw_addr_i,
  input  logic [7:0]               aw_len_i,
  input  logic                     w_valid_i,
  output logic                     w_ready_o,
  input  logic [DataWidth-1:0]     w_data_i,
  input  logic                     w_last_i,
  output logic                     b_valid_o,
  input  logic                     b_ready_i,
  output logic [1:0]               b_resp_o,
  output logic                     grant_valid_o,
  input  logic                     grant_ready_i,
  output xdma_from_remote_grant_t  grant_o,
  output logic                     finish_valid_o,
  input  logic                     finish_ready_i,
  output xdma_from_remote_finish_t finish_o,
  output logic                     cfg_valid_o,
  input  logic                     cfg_ready_i,
  output xdma_inter_cluster_cfg_t  cfg_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic [DataWidth-1:0]     data_o,
  output logic                     data_last_o
);

  localparam int unsigned MsgWidth = $bits(xdma_from_remote_grant_t);

  xdma_rx_state_e        state_q, state_d;
  xdma_from_remote_idx_e idx_q, dec_idx;
  logic                  miss_q, dec_miss;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt_q;
  logic                  err_q;
  logic                  drain_q;
  logic                  aw_hs, w_hs;

  xdma_mmio_window_decode i_decode (
    .addr (aw_addr_i),
    .base (cluster_base_addr_i),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i & w_ready_o;

  // Payloads are pure wiring from W; only the valids are steered.
  assign data_o      = w_data_i;
  assign data_last_o = w_last_i;
  assign grant_o     = w_data_i[DataWidth-1 -: MsgWidth];
  assign finish_o    = w_data_i[DataWidth-1 -: MsgWidth];
  assign cfg_o       = w_data_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (aw_hs) state_d = StBurst;
      StBurst: if (w_hs && w_last_i) state_d = StResp;
      StResp:  if (b_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    aw_ready_o     = 1'b0;
    w_ready_o      = 1'b0;
    b_valid_o      = 1'b0;
    b_resp_o       = RespOkay;
    grant_valid_o  = 1'b0;
    finish_valid_o = 1'b0;
    cfg_valid_o    = 1'b0;
    data_valid_o   = 1'b0;
    unique case (state_q)
      StIdle: aw_ready_o = 1'b1;
      StBurst: begin
        if (miss_q || drain_q) begin
          w_ready_o = 1'b1;
        end else if ((idx_q != IdxData) && (beat_cnt_q != 8'd0)) begin
          // Control windows carry one word; trailing beats are discarded.
          w_ready_o = 1'b1;
        end else begin
          unique case (idx_q)
            IdxFinish: begin
              finish_valid_o = w_valid_i;
              w_ready_o      = finish_ready_i;
            end
            IdxGrant: begin
              grant_valid_o = w_valid_i;
              w_ready_o     = grant_ready_i;
            end
            IdxCfg: begin
              cfg_valid_o = w_valid_i;
              w_ready_o   = cfg_ready_i;
            end
            IdxData: begin
              data_valid_o = w_valid_i;
              w_ready_o    = data_ready_i;
            end
            default: w_ready_o = 1'b1;
          endcase
        end
      end
      StResp: begin
        b_valid_o = 1'b1;
        b_resp_o  = err_q ? RespSlvErr : RespOkay;
      end
      default: aw_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= IdxFinish;
      miss_q     <= 1'b0;
      len_q      <= 8'd0;
      beat_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      drain_q    <= 1'b0;
    end else if (aw_hs) begin
      idx_q      <= dec_idx;
      miss_q     <= dec_miss;
      len_q      <= aw_len_i;
      beat_cnt_q <= 8'd0;
      drain_q    <= 1'b0;
      err_q      <= dec_miss || ((dec_idx != IdxData) && (aw_len_i != 8'd0));
    end else if (w_hs && (state_q == StBurst)) begin
      if (beat_cnt_q != 8'hFF) beat_cnt_q <= beat_cnt_q + 8'd1;
      if (w_last_i && (beat_cnt_q != len_q)) err_q <= 1'b1;
      // Overlong burst: flag it and swallow everything up to w_last.
      if (!w_last_i && (beat_cnt_q == len_q)) begin
        err_q   <= 1'b1;
        drain_q <= 1'b1;
      end
    end
  end

endmodule
